// File: rtl/uart_tx_ext.sv
// UART transmitter: start, DATA_BITS data (LSB first), optional parity, 1/2 stop bits; optional parity via UART_TX_PARITY_EN.
// Latency: start bit on tx_o the cycle after acceptance; frame lasts div*(1+DATA_BITS+P+S) clocks, done_o in its last cycle.
// Backpressure: ready_o high only in IDLE; valid_i ignored (not queued) while a frame is in flight.
module uart_tx_ext #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 valid_i,
    input  logic [DATA_BITS-1:0] d_i,
    input  logic [DIV_W-1:0]     div_i,
    input  logic [1:0]           parity_i,
    input  logic                 stop2_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     tmr_q, tmr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic [DIV_W-1:0]     div_in;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_odd_q, par_odd_d;
`else
    logic unused_parity;
    assign unused_parity = ^parity_i;
`endif

    // A zero divisor is treated as one clock per bit.
    assign div_in = (div_i == '0) ? DIV_W'(1) : div_i;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        div_d     = div_q;
        stop2_d   = stop2_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d   = S_START;
                    data_d    = d_i;
                    div_d     = div_in;
                    stop2_d   = stop2_i;
                    tmr_d     = div_in - DIV_W'(1);
                    cnt_d     = '0;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = (parity_i == 2'b01) || (parity_i == 2'b10);
                    par_odd_d = (parity_i == 2'b10);
`endif
                end
            end
            S_START: begin
                if (tmr_q == '0) begin
                    state_d = S_DATA;
                    tmr_d   = div_q - DIV_W'(1);
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (tmr_q == '0) begin
                    tmr_d = div_q - DIV_W'(1);
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q - DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tmr_q == '0) begin
                    state_d = S_STOP;
                    tmr_d   = div_q - DIV_W'(1);
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q - DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                // cnt_q indexes the stop bit (0 or 1).
                if (tmr_q == '0) begin
                    if (!stop2_q || (cnt_q == CNT_W'(1))) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CNT_W'(1);
                        tmr_d = div_q - DIV_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (tmr_d == '0) &&
                  (!stop2_d || (cnt_d == CNT_W'(1)));
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[cnt_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = (^data_d) ^ par_odd_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            div_q     <= '0;
            stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
`endif
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            div_q     <= div_d;
            stop2_q   <= stop2_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
`endif
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed + randomized frames for uart_tx_ext, checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_ext;
    localparam int DB = 8;
    localparam int DW = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          valid_i = 1'b0;
    logic [DB-1:0] d_i = '0;
    logic [DW-1:0] div_i = '0;
    logic [1:0]    parity_i = '0;
    logic          stop2_i = 1'b0;
    logic          ready_o, tx_o, busy_o, done_o;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_ext #(.DATA_BITS(DB), .DIV_W(DW)) dut (
        .clk(clk), .resetn(resetn), .valid_i(valid_i), .d_i(d_i), .div_i(div_i),
        .parity_i(parity_i), .stop2_i(stop2_i), .ready_o(ready_o), .tx_o(tx_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_div(input int dv);
        return (dv == 0) ? 1 : dv;
    endfunction

    function automatic bit has_par(input logic [1:0] par);
        return PEN && (par == 2'b01 || par == 2'b10);
    endfunction

    function automatic int nbits(input logic [1:0] par, input logic s2);
        return 1 + DB + (has_par(par) ? 1 : 0) + (s2 ? 2 : 1);
    endfunction

    // Line level of frame bit k, built as the list of bits the frame carries.
    function automatic logic bit_at(input logic [DB-1:0] d, input logic [1:0] par,
                                    input logic s2, input int k);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) q.push_back(d[i]);
        if (has_par(par)) q.push_back((^d) ^ (par == 2'b10));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        return q[k];
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge of the idle cycle after the frame.
    task automatic run_frame(input logic [DB-1:0] d, input int dv, input logic [1:0] par,
                             input logic s2, input bit hold, input logic [DB-1:0] nd,
                             output int dn_cnt, output int dn_at);
        int e, len;
        e   = eff_div(dv);
        len = e * nbits(par, s2);
        chk1("ready_before", ready_o, 1'b1);
        valid_i = 1'b1; d_i = d; div_i = DW'(dv); parity_i = par; stop2_i = s2;
        dn_cnt = 0; dn_at = 0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            chk1("tx", tx_o, bit_at(d, par, s2, c / e));
            chk1("busy", busy_o, 1'b1);
            chk1("ready_in_frame", ready_o, 1'b0);
            chk1("done", done_o, (c == len - 1));
            if (done_o === 1'b1) begin
                dn_cnt++;
                if (dn_at == 0) dn_at = c + 1;
            end
            if (hold) begin
                valid_i = 1'b1; d_i = nd;
            end else begin
                valid_i  = (c == len - 1) ? 1'b0 : 1'($urandom);
                d_i      = DB'($urandom);
                div_i    = DW'($urandom);
                parity_i = 2'($urandom);
                stop2_i  = 1'($urandom);
            end
        end
        @(negedge clk);
        chk1("idle_tx", tx_o, 1'b1);
        chk1("idle_ready", ready_o, 1'b1);
        chk1("idle_busy", busy_o, 1'b0);
        chk1("idle_done", done_o, 1'b0);
    endtask

    initial begin
        int dc, da;
        logic [DB-1:0] rd;
        int rdv;
        logic [1:0] rpar;
        logic rs2;

        repeat (2) @(negedge clk);
        chk1("rst_tx", tx_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_ready", ready_o, 1'b1);
        resetn = 1'b1;
        @(negedge clk);

        run_frame(8'hA5, 4, 2'b00, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("a5_div4_done_at", da, 40);
        chkn("a5_div4_done_cnt", dc, 1);

        run_frame(8'hA5, 4, 2'b01, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("even_done_at", da, PEN ? 44 : 40);
        run_frame(8'hA5, 4, 2'b10, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("odd_done_at", da, PEN ? 44 : 40);
        run_frame(8'hA5, 4, 2'b11, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("par11_done_at", da, 40);

        run_frame(8'h00, 3, 2'b00, 1'b1, 1'b0, 8'h00, dc, da);
        chkn("stop2_done_at", da, 33);

        run_frame(8'h01, 0, 2'b00, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("div0_done_at", da, 10);

        run_frame(8'h55, 2, 2'b00, 1'b0, 1'b1, 8'h0F, dc, da);
        chkn("b2b_first_done_cnt", dc, 1);
        run_frame(8'h0F, 2, 2'b00, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("b2b_second_done_at", da, 20);

        // Abort a div=4 frame during its 13th clock.
        rd = DB'($urandom);
        valid_i = 1'b1; d_i = rd; div_i = DW'(4); parity_i = 2'b00; stop2_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk1("abort_tx", tx_o, bit_at(rd, 2'b00, 1'b0, c / 4));
            valid_i = 1'b0;
        end
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk1("abort_rst_tx", tx_o, 1'b1);
        chk1("abort_rst_busy", busy_o, 1'b0);
        chk1("abort_rst_ready", ready_o, 1'b1);
        chk1("abort_rst_done", done_o, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk1("abort_no_done", done_o, 1'b0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk1("abort_rel_ready", ready_o, 1'b1);
        chk1("abort_rel_tx", tx_o, 1'b1);
        chk1("abort_rel_busy", busy_o, 1'b0);
        run_frame(8'h3C, 4, 2'b00, 1'b0, 1'b0, 8'h00, dc, da);
        chkn("after_abort_done_at", da, 40);

        for (int n = 0; n < 6; n++) begin
            rd   = DB'($urandom);
            rdv  = int'($urandom_range(0, 5));
            rpar = 2'($urandom);
            rs2  = 1'($urandom);
            run_frame(rd, rdv, rpar, rs2, 1'b0, 8'h00, dc, da);
            chkn("rand_done_at", da, eff_div(rdv) * nbits(rpar, rs2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
